// File: rtl/serial_add_seq.sv
// Bit-serial adder (LSB first, one full-adder slice): sum/carry_out land WIDTH edges after an accepted start.
// No backpressure: start is taken only in IDLE and dropped while busy. SERIAL_ADD_OVF_EN adds a signed-overflow output.
module serial_add_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic             carry;
   logic [CW-1:0]    count;

   logic             bit_s;
   logic             bit_c;
   logic             last_bit;

   assign bit_s    = shift_a[0] ^ shift_b[0] ^ carry;
   assign bit_c    = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
   assign last_bit = (count == CW'(WIDTH - 1));

   // shift_a doubles as the result register: sum bits enter at the MSB as operand bits leave the LSB
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state     <= IDLE;
         shift_a   <= '0;
         shift_b   <= '0;
         carry     <= 1'b0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_a <= a_in;
                  shift_b <= b_in;
                  carry   <= cin;
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               shift_a <= {bit_s, shift_a[WIDTH-1:1]};
               shift_b <= {1'b0, shift_b[WIDTH-1:1]};
               carry   <= bit_c;
               count   <= count + CW'(1);
               if (last_bit) begin
                  sum       <= {bit_s, shift_a[WIDTH-1:1]};
                  carry_out <= bit_c;
`ifdef SERIAL_ADD_OVF_EN
                  // on the MSB slice the carry flop holds the carry into the MSB
                  ovf       <= carry ^ bit_c;
`endif
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed literal cases, held start, mid-op clear, random traffic vs. a reference model.
`timescale 1ns/1ps
module tb_serial_add_seq;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clear;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: operation result computed arithmetically, timeline as edges since acceptance
   bit           m_active = 1'b0;
   int           m_t      = 0;
   logic [W-1:0] p_sum    = '0;
   logic         p_co     = 1'b0;
   logic         p_ovf    = 1'b0;
   logic [W-1:0] e_sum    = '0;
   logic         e_co     = 1'b0;
   logic         e_ovf    = 1'b0;

   serial_add_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .clear     (clear),
      .start     (start),
      .a_in      (a_in),
      .b_in      (b_in),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
     ,.ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_accept();
      int full, sa, sb, ss;
      full  = int'(a_in) + int'(b_in) + int'(cin);
      p_sum = W'(full % (1 << W));
      p_co  = (full >= (1 << W));
      sa    = int'(a_in) - (a_in[W-1] ? (1 << W) : 0);
      sb    = int'(b_in) - (b_in[W-1] ? (1 << W) : 0);
      ss    = sa + sb + int'(cin);
      p_ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
      int n;
      @(posedge clk); #1;
      a_in = a; b_in = b; cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      cmp({nm, "_latency"}, n, W);
      cmp({nm, "_sum"}, sum, es);
      cmp({nm, "_carry"}, carry_out, ec);
`ifdef SERIAL_ADD_OVF_EN
      cmp({nm, "_ovf"}, ovf, eo);
`else
      if (eo === 1'bx) $display("unexpected x in ovf expectation for %s", nm);
`endif
   endtask

   initial begin
      int dcount;
      clear = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
      #2;
      cmp("reset_busy", busy, 0);
      cmp("reset_done", done, 0);
      cmp("reset_sum", sum, 0);
      cmp("reset_carry", carry_out, 0);

      fork
         forever begin
            @(posedge clk or posedge clear);
            if (clear) begin
               m_active = 1'b0; m_t = 0;
               e_sum = '0; e_co = 1'b0; e_ovf = 1'b0;
            end else if (m_active) begin
               if (m_t == W) m_active = 1'b0;
               else begin
                  m_t++;
                  if (m_t == W) begin
                     e_sum = p_sum; e_co = p_co; e_ovf = p_ovf;
                  end
               end
            end else if (start) begin
               m_active = 1'b1;
               m_t = 0;
               model_accept();
            end
         end
         forever begin
            @(negedge clk);
            cmp("cyc_busy", busy, m_active);
            cmp("cyc_done", done, m_active && (m_t == W));
            cmp("cyc_sum", sum, e_sum);
            cmp("cyc_carry", carry_out, e_co);
`ifdef SERIAL_ADD_OVF_EN
            cmp("cyc_ovf", ovf, e_ovf);
`endif
         end
      join_none

      @(negedge clk);
      clear = 1'b0;

      do_op(4'd5,  4'd3,  1'b0, 4'd8, 1'b0, 1'b1, "op_5p3");
      do_op(4'd9,  4'd9,  1'b0, 4'd2, 1'b1, 1'b1, "op_9p9");
      do_op(4'd15, 4'd0,  1'b1, 4'd0, 1'b1, 1'b0, "op_15p0c");
      do_op(4'd0,  4'd0,  1'b0, 4'd0, 1'b0, 1'b0, "op_0p0");
      do_op(4'd7,  4'd1,  1'b0, 4'd8, 1'b0, 1'b1, "op_7p1");
      do_op(4'd7,  4'd15, 1'b0, 4'd6, 1'b1, 1'b0, "op_7pm1");

      // start held high with operands changing every cycle
      @(posedge clk); #1;
      start = 1'b1;
      dcount = 0;
      for (int i = 0; i < 3 * (W + 2); i++) begin
         @(posedge clk); #1;
         a_in = W'($urandom); b_in = W'($urandom); cin = 1'(($urandom));
         if (done) dcount++;
      end
      start = 1'b0;
      cmp("held_start_done_count", dcount, 3);

      // clear during the second SHIFT cycle
      do_op(4'd5, 4'd6, 1'b0, 4'd11, 1'b0, 1'b1, "op_5p6");
      @(posedge clk); #1;
      a_in = 4'd3; b_in = 4'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      clear = 1'b1;
      #1;
      cmp("clr_busy", busy, 0);
      cmp("clr_done", done, 0);
      cmp("clr_sum", sum, 0);
      cmp("clr_carry", carry_out, 0);
      @(negedge clk); #1;
      clear = 1'b0;
      do_op(4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, "op_2p2");

      // random traffic with occasional asynchronous clear pulses
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         start = 1'($urandom_range(0, 1));
         a_in  = W'($urandom);
         b_in  = W'($urandom);
         cin   = 1'($urandom);
         if ($urandom_range(0, 60) == 0) begin
            clear = 1'b1;
            #2;
            clear = 1'b0;
         end
      end
      start = 1'b0;
      repeat (W + 4) @(posedge clk);
      @(negedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
